// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter, single-outstanding instruction-memory read and a
// one-entry instruction buffer in front of the decoder. Taken branches redirect the fetch
// address and cause any stale in-flight read to be discarded.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        CLK,
    input  logic        Reset,
    output logic [63:0] IMemAddr,
    output logic        IMemReq,
    input  logic        IMemValid,
    input  logic [31:0] IMemData,
    output logic [31:0] Instruction,
    output logic [25:0] Imm25,
    output logic [63:0] PC,
    output logic        InstrValid,
    input  logic        InstrReady,
    input  logic        BrValid,
    input  logic        Branch,
    input  logic        Uncondbranch,
    input  logic        Zero,
    input  logic [63:0] BrPC,
    input  logic [63:0] BusImm
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] pc_q, pc_d;
    logic        valid_q, valid_d;

    logic        taken;
    logic [63:0] target;

    assign taken  = BrValid & (Uncondbranch | (Branch & Zero));
    // BusImm is a word offset; the wrap past 2^64 is intentional.
    assign target = BrPC + (BusImm << 2);

    // Next-state, fetch address and buffer update; a taken redirect overrides everything.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        instr_d    = instr_q;
        pc_d       = pc_q;
        valid_d    = valid_q;

        case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // The request at the old address still goes out; its data must be dropped.
                state_d = taken ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (taken) begin
                    state_d = IMemValid ? S_REQ : S_DROP;
                end else if (IMemValid) begin
                    instr_d    = IMemData;
                    pc_d       = fetch_pc_q;
                    valid_d    = 1'b1;
                    fetch_pc_d = fetch_pc_q + 64'd4;
                    state_d    = S_HOLD;
                end
            end
            S_HOLD: begin
                if (taken || (valid_q && InstrReady)) begin
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_DROP: begin
                if (IMemValid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (taken) begin
            fetch_pc_d = target & ~64'h3;
        end
    end

    // FSM state and fetch address registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    // Instruction buffer presented to the decoder.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            instr_q <= 32'h0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign IMemReq     = (state_q == S_REQ);
    assign IMemAddr    = fetch_pc_q;
    assign Instruction = instr_q;
    assign Imm25       = instr_q[25:0];
    assign PC          = pc_q;
    assign InstrValid  = valid_q;

endmodule
